// File: rtl/rv32im_dmem_ctrl_pkg.sv
// rtl/rv32im_dmem_ctrl_pkg.sv - shared definitions for the data-memory controller
// Holds the FSM state encoding, LSU opcode constants, bus widths and opcode decode helpers.
package rv32im_dmem_ctrl_pkg;

    localparam int LSU_OPCODE_WIDTH = 4;
    localparam int BUS_BE_WIDTH     = 4;
    localparam int LANE_DATA_WIDTH  = 32;

    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_NOP = 4'd0;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LB  = 4'd1;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LBU = 4'd2;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LH  = 4'd3;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LHU = 4'd4;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LW  = 4'd5;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SB  = 4'd6;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SH  = 4'd7;
    localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } dmem_state_e;

    function automatic logic is_mem_op(input logic [LSU_OPCODE_WIDTH-1:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [LSU_OPCODE_WIDTH-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [LSU_OPCODE_WIDTH-1:0] op,
                                           input logic [1:0] off);
        logic m;
        m = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: m = off[0];
            OP_LW, OP_SW:         m = (off != 2'b00);
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rv32im_dmem_ctrl_if.sv
// rtl/rv32im_dmem_ctrl_if.sv - word-addressed memory bus between controller and memory
// master: controller side (drives req/we/addr/be/wdata, receives rdata/ack/err).
// slave:  memory side.
interface rv32im_dmem_ctrl_if
    import rv32im_dmem_ctrl_pkg::*;
#(
    parameter int API_DATA_WIDTH = 32,
    parameter int API_ADDR_WIDTH = 32
);
    logic                      bus_req_o;
    logic                      bus_we_o;
    logic [API_ADDR_WIDTH-1:0] bus_addr_o;
    logic [BUS_BE_WIDTH-1:0]   bus_be_o;
    logic [API_DATA_WIDTH-1:0] bus_wdata_o;
    logic [API_DATA_WIDTH-1:0] bus_rdata_i;
    logic                      bus_ack_i;
    logic                      bus_err_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i, bus_err_i
    );
endinterface

// File: rtl/rv32im_dmem_ctrl_lane.sv
// rtl/rv32im_dmem_ctrl_lane.sv - byte-lane steering for the data-memory controller
// opcode/byte_off: access type and address[1:0]; store_data: right-aligned store value;
// rdata: raw bus word. be/wdata: lane enables and replicated store data; load_data:
// right-aligned, zero-filled load value.
module rv32im_dmem_lane
    import rv32im_dmem_ctrl_pkg::*;
(
    input  logic [LSU_OPCODE_WIDTH-1:0] opcode,
    input  logic [1:0]                  byte_off,
    input  logic [LANE_DATA_WIDTH-1:0]  store_data,
    input  logic [LANE_DATA_WIDTH-1:0]  rdata,
    output logic [BUS_BE_WIDTH-1:0]     be,
    output logic [LANE_DATA_WIDTH-1:0]  wdata,
    output logic [LANE_DATA_WIDTH-1:0]  load_data
);
    logic [LANE_DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted   = rdata >> {byte_off, 3'b000};
        be        = '0;
        wdata     = store_data;
        load_data = '0;
        case (opcode)
            OP_LB, OP_LBU, OP_SB: begin
                be        = 4'b0001 << byte_off;
                wdata     = {4{store_data[7:0]}};
                load_data = {24'b0, shifted[7:0]};
            end
            OP_LH, OP_LHU, OP_SH: begin
                be        = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {16'b0, shifted[15:0]};
            end
            OP_LW, OP_SW: begin
                be        = 4'b1111;
                load_data = shifted;
            end
            default: begin
                be = '0;
            end
        endcase
    end
endmodule

// File: rtl/rv32im_dmem_ctrl.sv
// rtl/rv32im_dmem_ctrl.sv - LSU to word-bus data-memory access controller
// clk_i/rst_i: clock, async active-high reset. req_i/lsu_opcode_i/addr_mem_i/val_memwr_i:
// LSU request. val_memrd_o: load result. stall_o/done_o/err_misalign_o/err_bus_o: status.
// bus: memory bus master port.
module rv32im_dmem_ctrl
    import rv32im_dmem_ctrl_pkg::*;
#(
    parameter int API_DATA_WIDTH = 32,
    parameter int API_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
    input  logic [API_ADDR_WIDTH-1:0]   addr_mem_i,
    input  logic [API_DATA_WIDTH-1:0]   val_memwr_i,
    output logic [API_DATA_WIDTH-1:0]   val_memrd_o,
    output logic                        stall_o,
    output logic                        done_o,
    output logic                        err_misalign_o,
    output logic                        err_bus_o,
    rv32im_dmem_ctrl_if.master          bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [LSU_OPCODE_WIDTH-1:0] op_q;
    logic [API_ADDR_WIDTH-1:0]   addr_q;
    logic [API_DATA_WIDTH-1:0]   data_q;
    logic                        misalign_q;

    logic [BUS_BE_WIDTH-1:0]     lane_be;
    logic [API_DATA_WIDTH-1:0]   lane_wdata;
    logic [API_DATA_WIDTH-1:0]   lane_load;

    logic accept;
    logic in_bus;

    assign accept = req_i && is_mem_op(lsu_opcode_i);
    assign in_bus = (state_q == ST_BUS);

    // Lane logic works from the captured request so bus outputs stay stable while waiting.
    rv32im_dmem_lane u_lane (
        .opcode     (op_q),
        .byte_off   (addr_q[1:0]),
        .store_data (data_q),
        .rdata      (bus.bus_rdata_i),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_misaligned(lsu_opcode_i, addr_mem_i[1:0]) ? ST_ERR : ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus.bus_ack_i) begin
                    state_d = bus.bus_err_i ? ST_ERR : ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            data_q      <= '0;
            misalign_q  <= 1'b0;
            val_memrd_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && accept) begin
                op_q       <= lsu_opcode_i;
                addr_q     <= addr_mem_i;
                data_q     <= val_memwr_i;
                misalign_q <= is_misaligned(lsu_opcode_i, addr_mem_i[1:0]);
                cnt_q      <= '0;
            end
            if (in_bus) begin
                if (!bus.bus_ack_i) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (!bus.bus_err_i && !is_store(op_q)) begin
                    val_memrd_o <= lane_load;
                end
            end
        end
    end

    // Status and bus outputs decode the registered state, so reset clears them at once.
    assign stall_o        = (state_q == ST_IDLE && accept) || in_bus;
    assign done_o         = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign err_misalign_o = (state_q == ST_ERR) && misalign_q;
    assign err_bus_o      = (state_q == ST_ERR) && !misalign_q;

    assign bus.bus_req_o   = in_bus;
    assign bus.bus_we_o    = in_bus && is_store(op_q);
    assign bus.bus_addr_o  = in_bus ? {addr_q[API_ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.bus_be_o    = in_bus ? lane_be : '0;
    assign bus.bus_wdata_o = in_bus ? lane_wdata : '0;
endmodule

// File: tb/tb_rv32im_dmem_ctrl.sv
// tb/tb_rv32im_dmem_ctrl.sv - self-checking bench for rv32im_dmem_ctrl
module tb_rv32im_dmem_ctrl;
    import rv32im_dmem_ctrl_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [3:0]  lsu_opcode_i = OP_NOP;
    logic [31:0] addr_mem_i = '0;
    logic [31:0] val_memwr_i = '0;
    logic [31:0] val_memrd_o;
    logic        stall_o, done_o, err_misalign_o, err_bus_o;

    rv32im_dmem_ctrl_if #(.API_DATA_WIDTH(32), .API_ADDR_WIDTH(32)) bus_if ();

    rv32im_dmem_ctrl #(.API_DATA_WIDTH(32), .API_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .lsu_opcode_i   (lsu_opcode_i),
        .addr_mem_i     (addr_mem_i),
        .val_memwr_i    (val_memwr_i),
        .val_memrd_o    (val_memrd_o),
        .stall_o        (stall_o),
        .done_o         (done_o),
        .err_misalign_o (err_misalign_o),
        .err_bus_o      (err_bus_o),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit          chk_en = 1'b0;
    bit          exp_stall, exp_done, exp_emis, exp_ebus, exp_breq, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;

    int          bus_cyc = 0, done_cnt = 0, emis_cnt = 0, ebus_cnt = 0;
    logic [3:0]  last_be;
    logic [31:0] last_wdata, last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_size(input logic [3:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        int off = int'(addr % 4);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        int sz = op_size(op);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
        int sz = op_size(op);
        int off = int'(addr % 4);
        longint mask = (longint'(1) << (8 * sz)) - 1;
        return 32'((64'(rd) >> (8 * off)) & mask);
    endfunction

    always @(negedge clk) begin
        if (bus_if.bus_req_o) begin
            bus_cyc++;
            last_be    = bus_if.bus_be_o;
            last_wdata = bus_if.bus_wdata_o;
            last_addr  = bus_if.bus_addr_o;
        end
        if (done_o) done_cnt++;
        if (err_misalign_o) emis_cnt++;
        if (err_bus_o) ebus_cnt++;
        if (chk_en) begin
            chk("stall", stall_o, exp_stall);
            chk("done", done_o, exp_done);
            chk("err_misalign", err_misalign_o, exp_emis);
            chk("err_bus", err_bus_o, exp_ebus);
            chk("bus_req", bus_if.bus_req_o, exp_breq);
            chk("val_memrd", val_memrd_o, exp_rd);
            if (exp_breq) begin
                chk("bus_we", bus_if.bus_we_o, exp_we);
                chk("bus_addr", bus_if.bus_addr_o, exp_addr);
                chk("bus_be", bus_if.bus_be_o, exp_be);
                if (exp_we) chk("bus_wdata", bus_if.bus_wdata_o, exp_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_stall = 0; exp_done = 0; exp_emis = 0; exp_ebus = 0; exp_breq = 0; exp_we = 0;
    endtask

    task automatic idle(input int n, input bit junk_ack);
        for (int i = 0; i < n; i++) begin
            step();
            req_i = 0;
            bus_if.bus_ack_i = junk_ack;
            bus_if.bus_err_i = junk_ack;
            bus_if.bus_rdata_i = 32'h5555_5555;
            set_idle();
        end
    endtask

    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_after, input bit berr,
                          input bit present_next);
        int sz = op_size(op);
        bit mis = (int'(addr % 4) % sz) != 0;
        bit tout = 0;
        step();
        bus_if.bus_ack_i = 0; bus_if.bus_err_i = 0; bus_if.bus_rdata_i = 32'hDEAD_DEAD;
        req_i = 1; lsu_opcode_i = op; addr_mem_i = addr; val_memwr_i = wd;
        set_idle(); exp_stall = 1;
        if (mis) begin
            step();
            req_i = 0;
            set_idle(); exp_done = 1; exp_emis = 1;
        end else begin
            for (int k = 0; k < TO; k++) begin
                step();
                req_i = 0;
                set_idle();
                exp_stall = 1; exp_breq = 1; exp_we = op_store(op);
                exp_addr = addr & ~32'd3; exp_be = m_be(op, addr); exp_wdata = m_wdata(op, wd);
                if (k == ack_after) begin
                    bus_if.bus_ack_i = 1; bus_if.bus_err_i = berr; bus_if.bus_rdata_i = rd;
                    break;
                end
                if (k == TO - 1) tout = 1;
            end
            step();
            bus_if.bus_ack_i = 0; bus_if.bus_err_i = 0; bus_if.bus_rdata_i = 32'hDEAD_DEAD;
            set_idle(); exp_done = 1; exp_ebus = berr || tout;
            if (!berr && !tout && !op_store(op)) exp_rd = m_rd(op, addr, rd);
        end
        if (present_next) begin
            req_i = 1; lsu_opcode_i = OP_LW; addr_mem_i = 32'h24; val_memwr_i = '0;
        end
    endtask

    initial begin
        int b0, d0, m0, e0;
        bus_if.bus_ack_i = 0; bus_if.bus_err_i = 0; bus_if.bus_rdata_i = '0;
        exp_rd = '0;
        set_idle();
        step();
        step();
        chk("rst_bus_req", bus_if.bus_req_o, 0);
        chk("rst_bus_we", bus_if.bus_we_o, 0);
        chk("rst_bus_addr", bus_if.bus_addr_o, 0);
        chk("rst_bus_be", bus_if.bus_be_o, 0);
        chk("rst_bus_wdata", bus_if.bus_wdata_o, 0);
        chk("rst_memrd", val_memrd_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_stall", stall_o, 0);
        rst_i = 0;
        chk_en = 1;

        // SB with ack in third bus cycle
        b0 = bus_cyc; d0 = done_cnt;
        access(OP_SB, 32'h1003, 32'h0000_00A5, 32'h0, 2, 0, 0);
        idle(1, 0);
        chk("sb_be", last_be, 4'b1000);
        chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", last_addr, 32'h1000);
        chk("sb_bus_cycles", bus_cyc - b0, 3);
        chk("sb_done_pulses", done_cnt - d0, 1);

        // LH upper half
        access(OP_LH, 32'h2002, 32'h0, 32'hBEEF_1234, 0, 0, 0);
        idle(1, 0);
        chk("lh_rd", val_memrd_o, 32'h0000_BEEF);
        chk("lh_be", last_be, 4'b1100);

        // LW misaligned
        b0 = bus_cyc; m0 = emis_cnt; d0 = done_cnt;
        access(OP_LW, 32'h0006, 32'h0, 32'h0, 0, 0, 0);
        idle(2, 0);
        chk("lw_mis_bus_cycles", bus_cyc - b0, 0);
        chk("lw_mis_pulses", emis_cnt - m0, 1);
        chk("lw_mis_done", done_cnt - d0, 1);

        // LW timeout
        b0 = bus_cyc; e0 = ebus_cnt;
        access(OP_LW, 32'h0100, 32'h0, 32'h0, -1, 0, 0);
        idle(1, 0);
        chk("to_bus_cycles", bus_cyc - b0, TO);
        chk("to_err_bus", ebus_cnt - e0, 1);
        chk("to_bus_req_low", bus_if.bus_req_o, 0);

        // SW with bus error
        e0 = ebus_cnt; d0 = done_cnt;
        access(OP_SW, 32'h0010, 32'h1111_2222, 32'h0, 1, 1, 0);
        idle(1, 1);
        chk("sw_err_bus", ebus_cnt - e0, 1);
        chk("sw_err_done", done_cnt - d0, 1);

        // assorted directed loads/stores, stray ack while idle in between
        access(OP_LB, 32'h3001, 32'h0, 32'h1122_3344, 0, 0, 0);
        idle(1, 1);
        chk("lb_rd", val_memrd_o, 32'h0000_0033);
        access(OP_LBU, 32'h3003, 32'h0, 32'h1122_3344, 1, 0, 0);
        idle(1, 0);
        access(OP_LHU, 32'h4000, 32'h0, 32'h1122_3344, 0, 0, 0);
        idle(1, 0);
        chk("lhu_rd", val_memrd_o, 32'h0000_3344);
        access(OP_SH, 32'h5002, 32'h1234_ABCD, 32'h0, 0, 0, 0);
        idle(1, 0);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        access(OP_SH, 32'h5001, 32'h1234_ABCD, 32'h0, 0, 0, 0);
        idle(1, 0);
        access(OP_LH, 32'h0003, 32'h0, 32'h0, 0, 0, 0);
        idle(1, 0);

        // non-memory opcodes are ignored
        step(); req_i = 1; lsu_opcode_i = OP_NOP; set_idle();
        step(); lsu_opcode_i = 4'hF; set_idle();
        step(); req_i = 0; set_idle();

        // back-to-back: request in done cycle is deferred one cycle
        access(OP_SW, 32'h0020, 32'hDEAD_BEEF, 32'h0, 0, 0, 1);
        access(OP_LW, 32'h0024, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
        idle(1, 0);
        chk("b2b_lw_rd", val_memrd_o, 32'hCAFE_F00D);

        // reset mid-bus
        d0 = done_cnt; m0 = emis_cnt; e0 = ebus_cnt;
        step(); req_i = 1; lsu_opcode_i = OP_SW; addr_mem_i = 32'h40; val_memwr_i = 32'h0102_0304;
        set_idle(); exp_stall = 1;
        for (int k = 0; k < 2; k++) begin
            step(); req_i = 0; set_idle();
            exp_stall = 1; exp_breq = 1; exp_we = 1; exp_addr = 32'h40; exp_be = 4'hF;
            exp_wdata = 32'h0102_0304;
        end
        chk("pre_rst_bus_req", bus_if.bus_req_o, 1);
        chk_en = 0;
        rst_i = 1;
        #1;
        chk("async_rst_bus_req", bus_if.bus_req_o, 0);
        chk("async_rst_bus_be", bus_if.bus_be_o, 0);
        chk("async_rst_done", done_o, 0);
        chk("async_rst_err_bus", err_bus_o, 0);
        chk("async_rst_memrd", val_memrd_o, 0);
        step();
        step();
        rst_i = 0;
        exp_rd = '0;
        set_idle();
        chk_en = 1;
        idle(3, 0);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_err", (emis_cnt - m0) + (ebus_cnt - e0), 0);

        // one more access after reset
        access(OP_LW, 32'h0044, 32'h0, 32'h0BAD_F00D, 2, 0, 0);
        idle(2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32im_dmem_ctrl.md
RV32IM_DMEM_CTRL -- requirements
Module: rv32im_dmem_ctrl

Interface
REQ-001 Parameter API_DATA_WIDTH, default 32: data word width; only 32 is supported.
REQ-002 Parameter API_ADDR_WIDTH, default 32: byte address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum wait for bus_ack_i before an error is raised.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 req_i  in  1  core requests a memory access this cycle.
REQ-008 lsu_opcode_i  in  LSU_OPCODE_WIDTH  LB/LBU/LH/LHU/LW/SB/SH/SW.
REQ-009 addr_mem_i  in  API_ADDR_WIDTH  byte address, driven by the LSU.
REQ-010 val_memwr_i  in  API_DATA_WIDTH  store data from the LSU, right-aligned.
REQ-011 val_memrd_o  out  API_DATA_WIDTH  load data to the LSU, right-aligned and zero-filled.
REQ-012 stall_o  out  1  core must hold its request.
REQ-013 done_o  out  1  one-cycle pulse when the access completes.
REQ-014 err_misalign_o  out  1  one-cycle pulse when the access is misaligned.
REQ-015 err_bus_o  out  1  one-cycle pulse on bus error or timeout.
REQ-016 bus_req_o  out  1  bus request; held until acknowledged.
REQ-017 bus_we_o  out  1  1 = write.
REQ-018 bus_addr_o  out  API_ADDR_WIDTH  word-aligned address ([1:0] = 0).
REQ-019 bus_be_o  out  4  byte-lane enables.
REQ-020 bus_wdata_o  out  API_DATA_WIDTH  lane-replicated store data.
REQ-021 bus_rdata_i  in  API_DATA_WIDTH  read data, valid with bus_ack_i.
REQ-022 bus_ack_i  in  1  transfer complete.
REQ-023 bus_err_i  in  1  transfer failed; qualified by bus_ack_i.

Function
REQ-024 FSM states: IDLE, BUS, RESP, ERR.
REQ-025 IDLE, req_i=1, valid memory opcode, aligned address: capture address, opcode and data, then go to BUS.
REQ-026 Misaligned access goes to ERR with no bus transaction:
- LH/LHU/SH with addr[0]=1.
- LW/SW with addr[1:0]!=0.
REQ-027 IDLE with req_i=1 and a non-memory opcode: the request is ignored and the FSM stays in IDLE.
REQ-028 In BUS, bus_req_o=1 and all bus_* outputs are driven from registers and held stable until bus_ack_i.
REQ-029 Byte enables:
- SB/LB/LBU: 1<<addr[1:0].
- SH/LH/LHU: 0011 if addr[1]=0, else 1100.
- SW/LW: 1111.
REQ-030 Write data: SB replicates the byte 4 times; SH replicates the halfword twice; SW passes the word through.
REQ-031 Read data: bus_rdata_i >> (8*addr[1:0]), masked to the access size, registered into val_memrd_o on ack.
REQ-032 BUS with bus_ack_i=1 and bus_err_i=0 goes to RESP; with bus_ack_i=1 and bus_err_i=1 it goes to ERR.
REQ-033 In BUS, a cycle counter increments each cycle without ack; when it reaches TIMEOUT_CYCLES the FSM goes to ERR and bus_req_o drops.
REQ-034 RESP: done_o=1 for exactly one cycle, then IDLE; val_memrd_o holds until the next load completes.
REQ-035 ERR: done_o=1 for one cycle, together with err_misalign_o or err_bus_o as applicable, then IDLE.
REQ-036 stall_o is high in IDLE when an accepted request is presented (combinational from req_i), and high in BUS; it is low in RESP and ERR.
REQ-037 Latency:
- Minimum access: request in cycle N, bus_req_o in N+1, ack in N+1, done_o in N+2.
- Misaligned access: done_o in N+1.
REQ-038 bus_ack_i while not in BUS is ignored.
REQ-039 Back-to-back: a request presented in the RESP cycle is not accepted; it is accepted in the following IDLE cycle.

Reset
REQ-040 On rst_i: state=IDLE, counter=0.
REQ-041 On rst_i: all outputs 0, including val_memrd_o and every bus_* output.
REQ-042 Reset during BUS drops bus_req_o immediately (asynchronously) and raises no done or error pulse.

Structure
REQ-043 The FSM state encoding and the LSU opcode constants belong in the shared DEFINITIONS.v.
REQ-044 Bus signal widths belong in memifdef.v.
REQ-045 One sub-module, rv32im_dmem_lane, contains the combinational byte-enable, write-replication and read-shift logic.

Verification
REQ-046 SB, addr=0x1003, data=0xA5, ack after 3 cycles -> bus_be_o=1000, bus_wdata_o=0xA5A5A5A5, bus_addr_o=0x1000, single done_o pulse.
REQ-047 LH, addr=0x2002, bus_rdata_i=0xBEEF1234 -> val_memrd_o=0x0000BEEF, bus_be_o=1100.
REQ-048 LW, addr=0x0006 -> err_misalign_o and done_o in N+1, bus_req_o never asserted.
REQ-049 LW with no ack, TIMEOUT_CYCLES=8 -> err_bus_o after 8 BUS cycles, bus_req_o deasserted.
REQ-050 SW with bus_ack_i=1 and bus_err_i=1 -> err_bus_o and done_o pulse; rst_i mid-BUS -> bus_req_o=0 immediately, no pulses.
